cic_diff_decimator: RTL
=======================

Name: cic_diff_decimator

Overview:
- Downstream stage of the differential VCO CIC filter.
- Consumes the signed (BW+1)-bit difference word every enabled CLK cycle.
- Performs integrate-and-dump decimation by a runtime-selectable power of two and buffers the results in a small FWFT FIFO.
- Presents decimated words on a valid/ready interface to the readout/serial logic, with a sticky overflow flag.

Parameters:
- BW, 5: input magnitude bits; input word is BW+1 bits signed (matches CIC output).
- DEC_LOG2_MAX, 4: maximum decimation exponent; decimation range 1..2^DEC_LOG2_MAX.
- FIFO_DEPTH, 4: output buffer entries, power of two, >=2.
- OW, BW+1+DEC_LOG2_MAX: output word width, signed (derived; do not override).

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RES  input  1  synchronous, active-high reset.
- ENABLE  input  1  sample-valid qualifier, same signal as driven to the CIC.
- IN  input  BW+1  signed CIC difference word, valid when ENABLE=1.
- DEC_SEL  input  clog2(DEC_LOG2_MAX+1)  decimation exponent; values >DEC_LOG2_MAX clamp to DEC_LOG2_MAX.
- OUT_DATA  output  OW  signed decimated sum, valid when OUT_VALID=1.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  consumer accepts OUT_DATA when OUT_VALID && OUT_READY.
- LEVEL  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- OVF  output  1  sticky: a decimated word was dropped.
- OVF_CLR  input  1  clears OVF.

Behaviour:
- Reset (RES=1 at a CLK edge): acc=0, cnt=0, dec_lat=0, FIFO empty.
  - Resulting outputs: OUT_VALID=0, OUT_DATA=0, LEVEL=0, OVF=0.
  - RES has priority over every other input, including mid-frame; a partial frame is discarded.
- Frame start (cnt==0 && ENABLE): dec_lat <= clamp(DEC_SEL). Changes to DEC_SEL mid-frame do not take effect until the next frame.
- Each ENABLE=1 cycle:
  - sum = acc + sign_ext(IN, OW).
  - If cnt == 2^dec_lat - 1: push sum, acc <= 0, cnt <= 0. Otherwise acc <= sum, cnt <= cnt+1.
  - dec_lat=0: every sample is pushed directly (bypass, decimation 1).
- ENABLE=0: acc, cnt and dec_lat hold; the FIFO read side keeps operating.
- Arithmetic: two's complement, no saturation. OW is sized so that 2^DEC_LOG2_MAX samples of full-scale input never wrap: -(2^BW)·2^DEC_LOG2_MAX .. (2^BW-1)·2^DEC_LOG2_MAX.
- Latency: a word pushed at edge N gives OUT_VALID=1 and OUT_DATA=word after edge N (FWFT, registered storage).
- Handshake:
  - Pop occurs on an edge where OUT_VALID && OUT_READY.
  - While OUT_VALID && !OUT_READY, OUT_DATA stays stable.
  - OUT_DATA is don't-care when OUT_VALID=0; it is driven 0 after reset.
- Full FIFO:
  - Push with no pop on the same edge: the new word is dropped, OVF <= 1, FIFO contents unchanged.
  - Simultaneous push and pop when full: both occur, no drop, LEVEL unchanged.
- Empty FIFO: a pop request is ignored (OUT_VALID=0). Simultaneous push while empty works normally.
- OVF: set by a drop, cleared by OVF_CLR. A drop and OVF_CLR on the same edge leave OVF=1. RES clears OVF.
- Pointers wrap modulo FIFO_DEPTH. LEVEL ranges 0..FIFO_DEPTH.

Decomposition:
- Shared package cic_pkg holds:
  - BW default and OW derivation function.
  - clog2 helper.
  - Default DEC_LOG2_MAX and FIFO_DEPTH constants, shared with the CIC and readout blocks.
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH). Ports: CLK, RES, push, push_data, pop, rd_data, empty, full, level. It is reused by the readout path.
- The integrate-and-dump counter/accumulator stays in the top module.

Test Plan:
- Reset mid-frame: DEC_SEL=2, feed 2 samples of +5, assert RES -> all outputs 0. The next 4 samples of +1 produce a single word 4, showing the partial frame was discarded.
- Constant input: DEC_SEL=2, IN=+3 every cycle, OUT_READY=1 -> word 12 every 4th cycle, OUT_VALID pulses one cycle each.
- Full-scale extremes: DEC_SEL=4, IN=-32 for 16 cycles -> -512; IN=+31 for 16 cycles -> 496; no wrap.
- ENABLE gaps and DEC_SEL change: DEC_SEL=1, IN=+2 with ENABLE alternating 1/0 -> word 4 every 4 CLK cycles. Change DEC_SEL to 3 mid-frame -> the current frame still closes after 2 samples, and the next word is 16.
- Backpressure/overflow: DEC_SEL=0, OUT_READY=0, IN=1..6 -> LEVEL reaches 4, OUT_DATA held at 1, words 5 and 6 dropped, OVF=1. Then assert OUT_READY -> words 1,2,3,4 are drained in order. Assert OVF_CLR -> OVF=0.
- Full push+pop: FIFO full, OUT_READY=1 on the same edge as a push -> no drop, LEVEL stays 4, OVF stays 0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the differential VCO CIC chain
// (CIC core, decimator and readout blocks).
package cic_pkg;

    localparam int BW_DEF           = 5;
    localparam int DEC_LOG2_MAX_DEF = 4;
    localparam int FIFO_DEPTH_DEF   = 4;

    // Ceiling log2, floored at 1 so it can always size a vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Output width that holds 2^dec_log2_max full-scale samples without wrapping.
    function automatic int ow_calc(input int bw, input int dec_log2_max);
        return bw + 1 + dec_log2_max;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered storage;
// the head entry is visible on rd_data whenever empty is low.
module sync_fifo_fwft
    import cic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RES,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH+1)-1:0] level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    always_comb begin
        do_pop_s  = pop & (level_r != LW'(0));
        do_push_s = push & ((level_r != LW'(DEPTH)) | do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (level_r == LW'(0));
    assign full    = (level_r == LW'(DEPTH));
    assign level   = level_r;

endmodule

// File: rtl/cic_diff_decimator.sv
// Integrate-and-dump decimator for the CIC difference word, by a runtime
// power of two, with a FWFT output buffer and sticky drop flag.
module cic_diff_decimator
    import cic_pkg::*;
#(
    parameter int BW           = BW_DEF,
    parameter int DEC_LOG2_MAX = DEC_LOG2_MAX_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                                CLK,
    input  logic                                RES,
    input  logic                                ENABLE,
    input  logic [BW:0]                         IN,
    input  logic [clog2(DEC_LOG2_MAX+1)-1:0]    DEC_SEL,
    output logic [ow_calc(BW, DEC_LOG2_MAX)-1:0] OUT_DATA,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic [clog2(FIFO_DEPTH+1)-1:0]      LEVEL,
    output logic                                OVF,
    input  logic                                OVF_CLR
);

    localparam int OW = ow_calc(BW, DEC_LOG2_MAX);
    localparam int SW = clog2(DEC_LOG2_MAX + 1);
    localparam int CW = (DEC_LOG2_MAX > 0) ? DEC_LOG2_MAX : 1;

    logic [OW-1:0] acc_r;
    logic [CW-1:0] cnt_r;
    logic [SW-1:0] dec_lat_r;
    logic          ovf_r;

    logic [SW-1:0] dec_eff_s;
    logic [SW-1:0] lat_s;
    logic [CW-1:0] term_s;
    logic [OW-1:0] sum_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          empty_s;
    logic          full_s;

    // Frame control; the first sample of a frame already uses the fresh exponent.
    always_comb begin
        if (DEC_SEL > SW'(DEC_LOG2_MAX)) begin
            dec_eff_s = SW'(DEC_LOG2_MAX);
        end else begin
            dec_eff_s = DEC_SEL;
        end
        lat_s  = (cnt_r == CW'(0)) ? dec_eff_s : dec_lat_r;
        term_s = ~({CW{1'b1}} << lat_s);
        sum_s  = acc_r + OW'(signed'(IN));
        push_s = ENABLE & (cnt_r == term_s);
        pop_s  = ~empty_s & OUT_READY;
        drop_s = push_s & full_s & ~pop_s;
    end

    // Accumulator, sample counter and latched exponent; all hold while ENABLE is low.
    always_ff @(posedge CLK) begin
        if (RES) begin
            acc_r     <= '0;
            cnt_r     <= '0;
            dec_lat_r <= '0;
        end else if (ENABLE) begin
            if (cnt_r == CW'(0)) begin
                dec_lat_r <= dec_eff_s;
            end
            if (push_s) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Sticky drop flag; a drop wins over a same-edge clear.
    always_ff @(posedge CLK) begin
        if (RES) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (OVF_CLR) begin
            ovf_r <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RES       (RES),
        .push      (push_s),
        .push_data (sum_s),
        .pop       (pop_s),
        .rd_data   (OUT_DATA),
        .empty     (empty_s),
        .full      (full_s),
        .level     (LEVEL)
    );

    assign OUT_VALID = ~empty_s;
    assign OVF       = ovf_r;

endmodule
